spi_master_tx_ctrl: RTL and testbench
=====================================

Name: spi_master_tx_ctrl

Overview:
Transmit-side companion to the SPI master RX control logic. On a start pulse it drains a programmed number of words from the TX FIFO (first-word-fall-through not assumed: read data valid one cycle after read enable). It presents each word to the SPI master core with a valid/ready handshake and pulses done when the last word is accepted. It sits between the host-loaded TX FIFO and the SPI master core, and sequences the weight/command load stage of a chip test.

Parameters:
DATA_WIDTH, 8, width of FIFO words and SPI TX data
CNT_WIDTH, 16, width of the transfer length counter

Ports:
clk  input  1  system clock
rst  input  1  system reset, asynchronous, active high
start  input  1  one-cycle pulse; begins a transfer of byte_count words
byte_count  input  CNT_WIDTH  number of words to send; sampled only on accepted start
fifo_empty  input  1  TX FIFO empty flag
fifo_read_en  output  1  TX FIFO read enable (active high)
fifo_read_data  input  DATA_WIDTH  TX FIFO read data, valid the cycle after fifo_read_en
spi_tx_ready  input  1  SPI master can accept a word
spi_tx_data_valid  output  1  spi_tx_data holds a word to send
spi_tx_data  output  DATA_WIDTH  word to SPI master
busy  output  1  transfer in progress
done  output  1  one-cycle pulse at end of transfer

Behaviour:
- Reset (async, rst=1): state IDLE, counter 0, data register 0; fifo_read_en=0, spi_tx_data_valid=0, spi_tx_data=0, busy=0, done=0. Reset mid-transfer aborts immediately. A word already read from the FIFO is discarded. No done pulse.
- States: IDLE, FETCH, LOAD, SEND, DONE. State, counter, data register, spi_tx_data_valid and done are registered.
- IDLE: start=1 latches byte_count into remaining. Next state is FETCH if byte_count!=0, else DONE. start in any other state is ignored.
- FETCH: fifo_read_en = (state==FETCH) & ~fifo_empty, combinational. If fifo_empty, hold FETCH (stall, no read). Otherwise go to LOAD.
- LOAD: capture fifo_read_data into the data register, then go to SEND. spi_tx_data_valid rises on entry to SEND.
- SEND: spi_tx_data_valid=1 and spi_tx_data stable until accepted. Acceptance is spi_tx_valid & spi_tx_ready at a rising edge.
- On acceptance in SEND: remaining decrements. If the new remaining is 0, go to DONE, else go to FETCH. spi_tx_data_valid drops the cycle after acceptance.
- DONE: done=1 for exactly one cycle, then IDLE.
- busy=1 in FETCH, LOAD, SEND and DONE; 0 in IDLE. busy rises the cycle after an accepted start.
- Latency with FIFO non-empty and ready tied high:
  - start at cycle 0; read_en at cycle 1; valid at cycle 3, accepted the same cycle.
  - Next read_en at cycle 4, giving one word per 3 cycles.
  - For N words, done is high at cycle 3N+1 (N>=1).
- byte_count=0: no FIFO reads and no valid. done is high the cycle after start (cycle 1), busy high for that single cycle.
- Counter is unsigned, no wrap: maximum transfer is 2^CNT_WIDTH-1 words.
- spi_tx_ready while not in SEND is ignored. fifo_read_data is ignored outside LOAD.
- The FIFO never underflows: fifo_read_en is never asserted while fifo_empty=1.

Test Plan:
- Basic transfer: FIFO preloaded A1,B2,C3, ready=1, start with byte_count=3 -> spi_tx_data A1,B2,C3 accepted at cycles 3,6,9; exactly 3 fifo_read_en pulses; done at cycle 10; busy cycles 1-10.
- Empty stall: byte_count=2, FIFO empty for 5 cycles after start, then 11,22 pushed -> no fifo_read_en while empty; words 11,22 sent in order; single done pulse.
- Backpressure: byte_count=2, ready held low 4 cycles in first SEND -> valid high and data 5A stable across stall; accepted only when ready=1; remaining decrements once per word.
- Zero length: start with byte_count=0 -> no read_en, no valid, done=1 at cycle 1, busy=1 only at cycle 1.
- Start while busy: second start with byte_count=7 during a 2-word transfer -> ignored; exactly 2 words sent; one done pulse.
- Reset mid-operation: rst asserted during SEND of word 2 of 4 -> all outputs 0 asynchronously, state IDLE, no done. A new start with byte_count=1 afterwards sends the next FIFO word normally.

Source files
------------

// File: rtl/spi_master_tx_ctrl.sv
// Transmit sequencer: drains byte_count words from a non-FWFT TX FIFO and
// hands each one to the SPI master core over a valid/ready handshake.
module spi_master_tx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  byte_count,
  input  logic                  fifo_empty,
  output logic                  fifo_read_en,
  input  logic [DATA_WIDTH-1:0] fifo_read_data,
  input  logic                  spi_tx_ready,
  output logic                  spi_tx_data_valid,
  output logic [DATA_WIDTH-1:0] spi_tx_data,
  output logic                  busy,
  output logic                  done
);

  // state | meaning
  // IDLE  | waiting for start; byte_count latched on start
  // FETCH | issue FIFO read once the FIFO is non-empty
  // LOAD  | FIFO data valid this cycle; capture into data register
  // SEND  | word presented to SPI core until accepted
  // DONE  | one-cycle done pulse, then back to IDLE
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    SEND  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t                state;
  state_t                next_state;
  logic [CNT_WIDTH-1:0]  remaining;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  accept;

  assign accept       = (state == SEND) & spi_tx_data_valid & spi_tx_ready;
  assign fifo_read_en = (state == FETCH) & ~fifo_empty;
  assign busy         = (state != IDLE);
  assign spi_tx_data  = data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      remaining         <= '0;
      data_q            <= '0;
      spi_tx_data_valid <= 1'b0;
      done              <= 1'b0;
    end else begin
      state             <= next_state;
      spi_tx_data_valid <= (next_state == SEND);
      done              <= (next_state == DONE);
      if ((state == IDLE) && start) begin
        remaining <= byte_count;
      end else if (accept) begin
        remaining <= remaining - CNT_ONE;
      end
      if (state == LOAD) begin
        data_q <= fifo_read_data;
      end
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          next_state = (byte_count != '0) ? FETCH : DONE;
        end
      end
      FETCH: begin
        if (!fifo_empty) begin
          next_state = LOAD;
        end
      end
      LOAD: next_state = SEND;
      SEND: begin
        // remaining still holds the pre-decrement count here
        if (accept) begin
          next_state = (remaining == CNT_ONE) ? DONE : FETCH;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_master_tx_ctrl.sv
// Scoreboard bench for spi_master_tx_ctrl: a queue-based FIFO model feeds the
// DUT, expected words are queued at push time and a negedge monitor compares.
module tb_spi_master_tx_ctrl;
  localparam int DW = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] byte_count = '0;
  logic          fifo_empty = 1'b1;
  logic          fifo_read_en;
  logic [DW-1:0] fifo_read_data = '0;
  logic          spi_tx_ready = 1'b0;
  logic          spi_tx_data_valid;
  logic [DW-1:0] spi_tx_data;
  logic          busy;
  logic          done;

  spi_master_tx_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .byte_count(byte_count),
    .fifo_empty(fifo_empty), .fifo_read_en(fifo_read_en),
    .fifo_read_data(fifo_read_data), .spi_tx_ready(spi_tx_ready),
    .spi_tx_data_valid(spi_tx_data_valid), .spi_tx_data(spi_tx_data),
    .busy(busy), .done(done)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_cyc = 0;
  int pend_done = 0;
  int done_cnt = 0;
  int valid_cycles = 0;
  logic done_prev = 1'b0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] pend_push[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] late_q[$];
  int acc_log[$];
  int rd_log[$];
  int busy_log[$];
  int done_log[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endfunction

  // FIFO model: read data appears the cycle after read enable
  always @(posedge clk) begin
    if (fifo_read_en) begin
      check("fifo_no_underflow", 64'(fifo_q.size() > 0), 64'd1);
      if (fifo_q.size() > 0) fifo_read_data <= fifo_q.pop_front();
    end
    while (pend_push.size() > 0) fifo_q.push_back(pend_push.pop_front());
    fifo_empty <= (fifo_q.size() == 0);
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (fifo_read_en) rd_log.push_back(cyc - start_cyc);
      if (busy) busy_log.push_back(cyc - start_cyc);
      if (spi_tx_data_valid) begin
        valid_cycles++;
        if (exp_q.size() == 0) begin
          check("unexpected_word", 64'(spi_tx_data_valid), 64'd0);
        end else begin
          check("tx_data", 64'(spi_tx_data), 64'(exp_q[0]));
          if (spi_tx_ready) begin
            acc_log.push_back(cyc - start_cyc);
            void'(exp_q.pop_front());
          end
        end
      end
      if (done) begin
        done_log.push_back(cyc - start_cyc);
        done_cnt++;
        check("done_expected", 64'(pend_done > 0), 64'd1);
        check("done_all_words_sent", 64'(exp_q.size()), 64'd0);
        check("done_single_cycle", 64'(done_prev), 64'd0);
        if (pend_done > 0) pend_done--;
      end
      done_prev = done;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    pend_push.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic do_start(input int n);
    acc_log.delete(); rd_log.delete(); busy_log.delete(); done_log.delete();
    valid_cycles = 0;
    byte_count = n[CW-1:0];
    start = 1'b1;
    start_cyc = cyc;
    pend_done++;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input bit rnd, input int maxc);
    int k = 0;
    while (done_cnt < target && k < maxc) begin
      tick(1);
      k++;
      if (rnd) spi_tx_ready = 1'($urandom_range(0, 1));
      if (late_q.size() > 0 && $urandom_range(0, 2) == 0) push_word(late_q.pop_front());
    end
    check("done_timeout", 64'(done_cnt >= target), 64'd1);
  endtask

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  initial begin
    int base;
    int k;
    bit mid_ok;
    tick(3);
    check("rst_read_en", 64'(fifo_read_en), 64'd0);
    check("rst_valid", 64'(spi_tx_data_valid), 64'd0);
    check("rst_data", 64'(spi_tx_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    rst = 1'b0;
    tick(2);

    // basic transfer, FIFO preloaded, ready high
    spi_tx_ready = 1'b1;
    push_word(8'hA1); push_word(8'hB2); push_word(8'hC3);
    tick(1);
    base = done_cnt;
    do_start(3);
    wait_done(base + 1, 1'b0, 100);
    for (int i = 0; i < 3; i++) begin
      check("basic_accept_cycle", 64'(at(acc_log, i)), 64'(3 * (i + 1)));
      check("basic_read_cycle", 64'(at(rd_log, i)), 64'(3 * i + 1));
    end
    check("basic_read_count", 64'(rd_log.size()), 64'd3);
    check("basic_done_cycle", 64'(at(done_log, 0)), 64'd10);
    check("basic_busy_len", 64'(busy_log.size()), 64'd10);
    check("basic_busy_first", 64'(at(busy_log, 0)), 64'd1);
    check("basic_busy_last", 64'(at(busy_log, 9)), 64'd10);
    tick(2);

    // zero length
    do_start(0);
    tick(4);
    check("zero_done_count", 64'(done_log.size()), 64'd1);
    check("zero_done_cycle", 64'(at(done_log, 0)), 64'd1);
    check("zero_busy_len", 64'(busy_log.size()), 64'd1);
    check("zero_busy_cycle", 64'(at(busy_log, 0)), 64'd1);
    check("zero_reads", 64'(rd_log.size()), 64'd0);
    check("zero_valid", 64'(valid_cycles), 64'd0);

    // empty stall
    base = done_cnt;
    do_start(2);
    repeat (5) begin
      tick(1);
      check("stall_no_read", 64'(fifo_read_en), 64'd0);
    end
    push_word(8'h11); push_word(8'h22);
    wait_done(base + 1, 1'b0, 100);
    tick(2);
    check("stall_words", 64'(acc_log.size()), 64'd2);
    check("stall_reads", 64'(rd_log.size()), 64'd2);
    check("stall_done_count", 64'(done_log.size()), 64'd1);

    // backpressure
    spi_tx_ready = 1'b0;
    push_word(8'h5A); push_word(8'h6B);
    tick(1);
    base = done_cnt;
    do_start(2);
    k = 0;
    while (!spi_tx_data_valid && k < 20) begin
      tick(1);
      k++;
    end
    check("bp_valid_seen", 64'(spi_tx_data_valid), 64'd1);
    repeat (4) begin
      tick(1);
      check("bp_valid_held", 64'(spi_tx_data_valid), 64'd1);
      check("bp_data_held", 64'(spi_tx_data), 64'h5A);
    end
    check("bp_no_accept", 64'(acc_log.size()), 64'd0);
    spi_tx_ready = 1'b1;
    wait_done(base + 1, 1'b0, 100);
    check("bp_words", 64'(acc_log.size()), 64'd2);
    tick(2);

    // start while busy is ignored
    push_word(8'h33); push_word(8'h44);
    tick(1);
    base = done_cnt;
    do_start(2);
    byte_count = 16'd7;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_done(base + 1, 1'b0, 100);
    tick(10);
    check("busy_start_words", 64'(acc_log.size()), 64'd2);
    check("busy_start_done", 64'(done_log.size()), 64'd1);
    check("busy_start_busy_len", 64'(busy_log.size()), 64'd7);
    check("busy_start_reads", 64'(rd_log.size()), 64'd2);

    // reset during SEND of word 2 of 4
    spi_tx_ready = 1'b0;
    push_word(8'hC1); push_word(8'hC2); push_word(8'hC3); push_word(8'hC4);
    tick(1);
    base = done_cnt;
    do_start(4);
    mid_ok = 1'b0;
    k = 0;
    while (!mid_ok && k < 60) begin
      tick(1);
      k++;
      spi_tx_ready = 1'b0;
      if (spi_tx_data_valid) begin
        if (acc_log.size() == 0) spi_tx_ready = 1'b1;
        else mid_ok = 1'b1;
      end
    end
    check("mid_reached_word2", 64'(mid_ok), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_read_en", 64'(fifo_read_en), 64'd0);
    check("mid_rst_valid", 64'(spi_tx_data_valid), 64'd0);
    check("mid_rst_data", 64'(spi_tx_data), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    tick(2);
    rst = 1'b0;
    exp_q.delete();
    pend_done = 0;
    tick(2);
    check("mid_no_done", 64'(done_cnt), 64'(base));
    check("mid_idle_after", 64'(busy), 64'd0);
    spi_tx_ready = 1'b1;
    exp_q.push_back(8'hC3);
    do_start(1);
    wait_done(base + 1, 1'b0, 100);
    check("post_rst_words", 64'(acc_log.size()), 64'd1);
    tick(1);
    exp_q.push_back(8'hC4);
    do_start(1);
    wait_done(base + 2, 1'b0, 100);
    tick(2);

    // randomized transfers with random ready and late FIFO fill
    for (int it = 0; it < 10; it++) begin
      int n;
      int pre;
      n = $urandom_range(1, 6);
      pre = $urandom_range(0, n);
      for (int j = 0; j < n; j++) begin
        logic [DW-1:0] w;
        w = DW'($urandom);
        if (j < pre) push_word(w);
        else late_q.push_back(w);
      end
      tick(1);
      base = done_cnt;
      do_start(n);
      wait_done(base + 1, 1'b1, 500);
      check("rand_words", 64'(acc_log.size()), 64'(n));
      check("rand_reads", 64'(rd_log.size()), 64'(n));
      spi_tx_ready = 1'b1;
      tick(2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
